// File: rtl/cpu_defs.sv
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Opcode constants, instruction field slices and decode helpers
//                shared by the ID stage and its register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam int INSTR_W = 32;
    localparam int FIELD_W = 5;
    localparam int IMM_W   = 16;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    typedef logic [FIELD_W-1:0] reg_field_t;

    typedef struct packed {
        logic [5:0]       opcode;
        reg_field_t       rs;
        reg_field_t       rt;
        reg_field_t       rd;
        logic [IMM_W-1:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f.opcode = instr[OPC_HI:OPC_LO];
        f.rs     = instr[RS_HI:RS_LO];
        f.rt     = instr[RT_HI:RT_LO];
        f.rd     = instr[RD_HI:RD_LO];
        f.imm    = instr[IMM_HI:IMM_LO];
        return f;
    endfunction

    // Logical immediates treat the 16-bit field as an unsigned mask.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage : cpu_defs

`default_nettype wire

// File: rtl/reg_file_bypass.sv
// ============================================================================
//  Module      : reg_file_bypass
//  Description : NUM_REGS x DATA_W register file, 2 combinational read ports
//                with write-through bypass, 1 write port, hardwired zero reg.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_bypass
    import cpu_defs::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_we,
    input  logic [$clog2(NUM_REGS)-1:0] i_waddr,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [FIELD_W-1:0]          i_raddr1,
    input  logic [FIELD_W-1:0]          i_raddr2,
    output logic [DATA_W-1:0]           o_rdata1,
    output logic [DATA_W-1:0]           o_rdata2
);

    localparam int REG_AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_waddr_ok;
    logic              w_wr_en;

    if (NUM_REGS < (1 << REG_AW)) begin : g_wpartial
        assign w_waddr_ok = (i_waddr < REG_AW'(NUM_REGS));
    end else begin : g_wfull
        assign w_waddr_ok = 1'b1;
    end

    assign w_wr_en = i_we && (i_waddr != '0) && w_waddr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [FIELD_W-1:0] w_addr;
        logic               w_addr_ok;
        logic [DATA_W-1:0]  w_data;

        assign w_addr = (p == 0) ? i_raddr1 : i_raddr2;

        // Instruction fields are always 5 bits; smaller files must reject the excess.
        if (NUM_REGS < (1 << FIELD_W)) begin : g_rpartial
            assign w_addr_ok = (w_addr < FIELD_W'(NUM_REGS));
        end else begin : g_rfull
            assign w_addr_ok = 1'b1;
        end

        always_comb begin
            w_data = '0;
            if ((w_addr == '0) || !w_addr_ok) begin
                w_data = '0;
            end else if (w_wr_en && (FIELD_W'(i_waddr) == w_addr)) begin
                w_data = i_wdata;
            end else begin
                w_data = r_regs[w_addr[REG_AW-1:0]];
            end
        end
    end

    assign o_rdata1 = g_rd[0].w_data;
    assign o_rdata2 = g_rd[1].w_data;

endmodule : reg_file_bypass

`default_nettype wire

// File: rtl/decode_stage_param.sv
// ============================================================================
//  Module      : decode_stage_param
//  Description : Parametrised ID stage - field decode, register read with
//                bypass, immediate extension, load-use detect, ID/EX register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage_param
    import cpu_defs::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int JUMP_W   = 7
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 instruction,
    input  logic                        instrValid,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        regWrite,
    input  logic [$clog2(NUM_REGS)-1:0] writeAddr,
    input  logic [DATA_W-1:0]           writeData,
    output logic [5:0]                  opCode,
    output logic [JUMP_W-1:0]           jumpAddrOut,
    output logic [JUMP_W-1:0]           jrAddrOut,
    output logic                        hazardStall,
    output logic                        valid_DE,
    output logic [5:0]                  opCode_DE,
    output logic [$clog2(NUM_REGS)-1:0] rs_FD,
    output logic [$clog2(NUM_REGS)-1:0] rt_FD,
    output logic [$clog2(NUM_REGS)-1:0] rd_FD,
    output logic [DATA_W-1:0]           readData_1,
    output logic [DATA_W-1:0]           readData_2,
    output logic [DATA_W-1:0]           immediate
);

    localparam int REG_AW = $clog2(NUM_REGS);

    typedef struct packed {
        logic              valid;
        logic [5:0]        opcode;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
    } idex_t;

    instr_fields_t     w_f;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic signed [IMM_W-1:0] w_imm_s;
    logic [DATA_W-1:0] w_imm;
    logic              w_hazard;
    idex_t             w_nxt;
    logic              w_load;
    idex_t             r_idex;

    assign w_f = split_instr(instruction);

    reg_file_bypass #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk      (clock),
        .rst      (reset),
        .i_we     (regWrite),
        .i_waddr  (writeAddr),
        .i_wdata  (writeData),
        .i_raddr1 (w_f.rs),
        .i_raddr2 (w_f.rt),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    assign w_imm_s = $signed(w_f.imm);

    always_comb begin
        w_imm = DATA_W'(w_f.imm);
        if (!is_zero_ext(w_f.opcode)) begin
            w_imm = DATA_W'(w_imm_s);
        end
    end

    // A load in EX whose target feeds the instruction now in ID cannot be forwarded in time.
    assign w_hazard = r_idex.valid && (r_idex.opcode == OP_LW) && (r_idex.rt != '0)
                   && instrValid
                   && ((FIELD_W'(r_idex.rt) == w_f.rs) || (FIELD_W'(r_idex.rt) == w_f.rt));

    always_comb begin
        w_nxt  = '0;
        w_load = 1'b1;
        if (flush) begin
            w_nxt = '0;
        end else if (stall) begin
            w_load = 1'b0;
        end else if (w_hazard) begin
            w_nxt = '0;
        end else begin
            w_nxt.valid  = instrValid;
            w_nxt.opcode = w_f.opcode;
            w_nxt.rs     = REG_AW'(w_f.rs);
            w_nxt.rt     = REG_AW'(w_f.rt);
            w_nxt.rd     = REG_AW'(w_f.rd);
            w_nxt.rdata1 = w_rd1;
            w_nxt.rdata2 = w_rd2;
            w_nxt.imm    = w_imm;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idex <= '0;
        end else if (w_load) begin
            r_idex <= w_nxt;
        end
    end

    assign opCode      = w_f.opcode;
    assign jumpAddrOut = instruction[JUMP_W-1:0];
    assign jrAddrOut   = w_rd1[JUMP_W-1:0];
    assign hazardStall = w_hazard;
    assign valid_DE    = r_idex.valid;
    assign opCode_DE   = r_idex.opcode;
    assign rs_FD       = r_idex.rs;
    assign rt_FD       = r_idex.rt;
    assign rd_FD       = r_idex.rd;
    assign readData_1  = r_idex.rdata1;
    assign readData_2  = r_idex.rdata2;
    assign immediate   = r_idex.imm;

endmodule : decode_stage_param

`default_nettype wire

// File: tb/tb_decode_stage_param.sv
// ============================================================================
//  Module      : tb_decode_stage_param
//  Description : Directed bench for decode_stage_param, default build plus a
//                16-register / 16-bit build driven from the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_param;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instrValid;
    logic        stall;
    logic        flush;
    logic        regWrite;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;

    logic [5:0]  opCode;
    logic [6:0]  jumpAddrOut;
    logic [6:0]  jrAddrOut;
    logic        hazardStall;
    logic        valid_DE;
    logic [5:0]  opCode_DE;
    logic [4:0]  rs_FD, rt_FD, rd_FD;
    logic [31:0] readData_1, readData_2, immediate;

    logic [5:0]  s_opCode;
    logic [6:0]  s_jumpAddrOut;
    logic [6:0]  s_jrAddrOut;
    logic        s_hazardStall;
    logic        s_valid_DE;
    logic [5:0]  s_opCode_DE;
    logic [3:0]  s_rs_FD, s_rt_FD, s_rd_FD;
    logic [15:0] s_readData_1, s_readData_2, s_immediate;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    decode_stage_param #(.DATA_W(32), .NUM_REGS(32), .JUMP_W(7)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .instrValid(instrValid),
        .stall(stall), .flush(flush), .regWrite(regWrite), .writeAddr(writeAddr),
        .writeData(writeData), .opCode(opCode), .jumpAddrOut(jumpAddrOut),
        .jrAddrOut(jrAddrOut), .hazardStall(hazardStall), .valid_DE(valid_DE),
        .opCode_DE(opCode_DE), .rs_FD(rs_FD), .rt_FD(rt_FD), .rd_FD(rd_FD),
        .readData_1(readData_1), .readData_2(readData_2), .immediate(immediate)
    );

    decode_stage_param #(.DATA_W(16), .NUM_REGS(16), .JUMP_W(7)) dut_s (
        .clock(clock), .reset(reset), .instruction(instruction), .instrValid(instrValid),
        .stall(stall), .flush(flush), .regWrite(regWrite), .writeAddr(writeAddr[3:0]),
        .writeData(writeData[15:0]), .opCode(s_opCode), .jumpAddrOut(s_jumpAddrOut),
        .jrAddrOut(s_jrAddrOut), .hazardStall(s_hazardStall), .valid_DE(s_valid_DE),
        .opCode_DE(s_opCode_DE), .rs_FD(s_rs_FD), .rt_FD(s_rt_FD), .rd_FD(s_rd_FD),
        .readData_1(s_readData_1), .readData_2(s_readData_2), .immediate(s_immediate)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 11'h020};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; instruction = 32'h0; instrValid = 1'b0; stall = 1'b0;
        flush = 1'b0; regWrite = 1'b0; writeAddr = 5'd0; writeData = 32'h0;
        tick();
        tick();
        total++; if (valid_DE !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", valid_DE); end
        total++; if (readData_1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%0h exp=0", readData_1); end
        total++; if (immediate !== 32'h0) begin bad++; $display("FAIL reset_imm got=%0h exp=0", immediate); end
        total++; if (s_valid_DE !== 1'b0) begin bad++; $display("FAIL reset_s_valid got=%0h exp=0", s_valid_DE); end
        reset = 1'b0;
    endtask

    task automatic test_regfile();
        for (int i = 1; i <= 15; i++) begin
            regWrite = 1'b1; writeAddr = 5'(i); writeData = 32'(16 - i);
            tick();
        end
        regWrite = 1'b0;
        instruction = rtype(5'd3, 5'd13, 5'd1); instrValid = 1'b1;
        tick();
        total++; if (readData_1 !== 32'd13) begin bad++; $display("FAIL rf_rd1 got=%0h exp=d", readData_1); end
        total++; if (readData_2 !== 32'd3) begin bad++; $display("FAIL rf_rd2 got=%0h exp=3", readData_2); end
        total++; if (valid_DE !== 1'b1) begin bad++; $display("FAIL rf_valid got=%0h exp=1", valid_DE); end
        total++; if ({rs_FD, rt_FD, rd_FD} !== {5'd3, 5'd13, 5'd1})
            begin bad++; $display("FAIL rf_fields got=%0d/%0d/%0d exp=3/13/1", rs_FD, rt_FD, rd_FD); end
        total++; if (immediate !== 32'h0000_0820) begin bad++; $display("FAIL rf_imm got=%0h exp=820", immediate); end
        total++; if ({s_readData_1, s_readData_2} !== {16'd13, 16'd3})
            begin bad++; $display("FAIL rf_s_rd got=%0h/%0h exp=d/3", s_readData_1, s_readData_2); end
        total++; if (s_valid_DE !== 1'b1) begin bad++; $display("FAIL rf_s_valid got=%0h exp=1", s_valid_DE); end
    endtask

    task automatic test_bypass();
        regWrite = 1'b1; writeAddr = 5'd5; writeData = 32'h0000_DEAD;
        instruction = rtype(5'd5, 5'd0, 5'd2); instrValid = 1'b1;
        #1;
        total++; if (jrAddrOut !== 7'h2D) begin bad++; $display("FAIL byp_jr got=%0h exp=2d", jrAddrOut); end
        tick();
        total++; if (readData_1 !== 32'h0000_DEAD) begin bad++; $display("FAIL byp_rd1 got=%0h exp=dead", readData_1); end
        total++; if (readData_2 !== 32'h0) begin bad++; $display("FAIL byp_rd2 got=%0h exp=0", readData_2); end
        total++; if (s_readData_1 !== 16'hDEAD) begin bad++; $display("FAIL byp_s_rd1 got=%0h exp=dead", s_readData_1); end
        writeAddr = 5'd0; writeData = 32'd7;
        instruction = rtype(5'd0, 5'd5, 5'd2);
        tick();
        total++; if (readData_1 !== 32'h0) begin bad++; $display("FAIL r0_bypass got=%0h exp=0", readData_1); end
        total++; if (readData_2 !== 32'h0000_DEAD) begin bad++; $display("FAIL byp_stored got=%0h exp=dead", readData_2); end
        regWrite = 1'b0;
        instruction = rtype(5'd0, 5'd0, 5'd0);
        tick();
        total++; if (readData_1 !== 32'h0) begin bad++; $display("FAIL r0_stored got=%0h exp=0", readData_1); end
        total++; if (s_readData_1 !== 16'h0) begin bad++; $display("FAIL r0_s_stored got=%0h exp=0", s_readData_1); end
    endtask

    task automatic test_immediate();
        instruction = itype(6'h08, 5'd1, 5'd2, 16'hFFF8);
        #1;
        total++; if (opCode !== 6'h08) begin bad++; $display("FAIL imm_opcode got=%0h exp=8", opCode); end
        total++; if (jumpAddrOut !== 7'h78) begin bad++; $display("FAIL imm_jump got=%0h exp=78", jumpAddrOut); end
        tick();
        total++; if (immediate !== 32'hFFFF_FFF8) begin bad++; $display("FAIL imm_addi got=%0h exp=fffffff8", immediate); end
        total++; if (s_immediate !== 16'hFFF8) begin bad++; $display("FAIL imm_s_addi got=%0h exp=fff8", s_immediate); end
        total++; if (opCode_DE !== 6'h08) begin bad++; $display("FAIL imm_opde got=%0h exp=8", opCode_DE); end
        instruction = itype(6'h0D, 5'd1, 5'd2, 16'hFFF8);
        tick();
        total++; if (immediate !== 32'h0000_FFF8) begin bad++; $display("FAIL imm_ori got=%0h exp=fff8", immediate); end
        total++; if (s_immediate !== 16'hFFF8) begin bad++; $display("FAIL imm_s_ori got=%0h exp=fff8", s_immediate); end
        instruction = itype(6'h0C, 5'd1, 5'd2, 16'h8001);
        tick();
        total++; if (immediate !== 32'h0000_8001) begin bad++; $display("FAIL imm_andi got=%0h exp=8001", immediate); end
    endtask

    task automatic test_load_use();
        instruction = itype(6'h23, 5'd1, 5'd4, 16'h0);
        tick();
        total++; if ({valid_DE, opCode_DE, rt_FD} !== {1'b1, 6'h23, 5'd4})
            begin bad++; $display("FAIL lu_lw got=%0h/%0h/%0d exp=1/23/4", valid_DE, opCode_DE, rt_FD); end
        instruction = rtype(5'd4, 5'd2, 5'd6);
        #1;
        total++; if (hazardStall !== 1'b1) begin bad++; $display("FAIL lu_hazard got=%0h exp=1", hazardStall); end
        tick();
        total++; if (valid_DE !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h exp=0", valid_DE); end
        total++; if (opCode_DE !== 6'h00 || readData_1 !== 32'h0)
            begin bad++; $display("FAIL lu_bubble_fields got=%0h/%0h exp=0/0", opCode_DE, readData_1); end
        total++; if (hazardStall !== 1'b0) begin bad++; $display("FAIL lu_drop got=%0h exp=0", hazardStall); end
        tick();
        total++; if ({valid_DE, rs_FD, rd_FD} !== {1'b1, 5'd4, 5'd6})
            begin bad++; $display("FAIL lu_add got=%0h/%0d/%0d exp=1/4/6", valid_DE, rs_FD, rd_FD); end
        total++; if ({readData_1, readData_2} !== {32'd12, 32'd14})
            begin bad++; $display("FAIL lu_add_data got=%0h/%0h exp=c/e", readData_1, readData_2); end
        instruction = itype(6'h23, 5'd1, 5'd0, 16'h0);
        tick();
        instruction = rtype(5'd0, 5'd2, 5'd6);
        #1;
        total++; if (hazardStall !== 1'b0) begin bad++; $display("FAIL lu_r0 got=%0h exp=0", hazardStall); end
        instruction = itype(6'h23, 5'd1, 5'd9, 16'h0);
        tick();
        instruction = rtype(5'd2, 5'd9, 5'd6);
        #1;
        total++; if (hazardStall !== 1'b1) begin bad++; $display("FAIL lu_rt got=%0h exp=1", hazardStall); end
        tick();
        tick();
    endtask

    task automatic test_stall_flush();
        instruction = rtype(5'd3, 5'd13, 5'd1);
        tick();
        total++; if (readData_1 !== 32'd13) begin bad++; $display("FAIL st_pre got=%0h exp=d", readData_1); end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instruction = rtype(5'(7 + k), 5'd8, 5'd9);
            regWrite = (k == 0); writeAddr = 5'd3; writeData = 32'h55;
            tick();
            total++; if ({valid_DE, rs_FD, readData_1} !== {1'b1, 5'd3, 32'd13})
                begin bad++; $display("FAIL st_hold%0d got=%0h/%0d/%0h exp=1/3/d", k, valid_DE, rs_FD, readData_1); end
        end
        regWrite = 1'b0;
        flush = 1'b1;
        tick();
        total++; if (valid_DE !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0h exp=0", valid_DE); end
        total++; if (readData_1 !== 32'h0) begin bad++; $display("FAIL fl_rd1 got=%0h exp=0", readData_1); end
        flush = 1'b0; stall = 1'b0;
        instruction = rtype(5'd3, 5'd13, 5'd1);
        tick();
        total++; if ({valid_DE, readData_1} !== {1'b1, 32'h55})
            begin bad++; $display("FAIL st_write got=%0h/%0h exp=1/55", valid_DE, readData_1); end
    endtask

    task automatic test_reset_mid();
        instruction = itype(6'h23, 5'd1, 5'd4, 16'h0);
        tick();
        instruction = rtype(5'd4, 5'd2, 5'd6);
        reset = 1'b1;
        #1;
        total++; if (hazardStall !== 1'b1) begin bad++; $display("FAIL rm_pending got=%0h exp=1", hazardStall); end
        tick();
        total++; if ({valid_DE, opCode_DE, rt_FD, readData_1, immediate} !== '0)
            begin bad++; $display("FAIL rm_clear got=%0h/%0h/%0d/%0h/%0h exp=0", valid_DE, opCode_DE, rt_FD, readData_1, immediate); end
        total++; if (hazardStall !== 1'b0) begin bad++; $display("FAIL rm_hazard got=%0h exp=0", hazardStall); end
        reset = 1'b0;
        instruction = rtype(5'd3, 5'd13, 5'd1);
        tick();
        total++; if ({valid_DE, readData_1, readData_2} !== {1'b1, 32'h0, 32'h0})
            begin bad++; $display("FAIL rm_regs got=%0h/%0h/%0h exp=1/0/0", valid_DE, readData_1, readData_2); end
        total++; if ({s_readData_1, s_readData_2} !== 32'h0)
            begin bad++; $display("FAIL rm_s_regs got=%0h/%0h exp=0/0", s_readData_1, s_readData_2); end
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_bypass();
        test_immediate();
        test_load_use();
        test_stall_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_decode_stage_param

`default_nettype wire
